// File: rtl/tick_sequencer.sv
// Tick enable generator for the core's register banks: free-run at a divided rate,
// single-step over a 4-phase req/ack handshake, or a counted burst.
module tick_sequencer #(
  parameter int DIV_BITS   = 16,
  parameter int BURST_BITS = 8,
  parameter int CNT_BITS   = 16
) (
  input  logic                  s_clock,
  input  logic                  reset,
  input  logic                  run_i,
  input  logic                  step_req_i,
  output logic                  step_ack_o,
  input  logic                  burst_start_i,
  input  logic [BURST_BITS-1:0] burst_len_i,
  input  logic [DIV_BITS-1:0]   div_i,
  output logic                  tick_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [CNT_BITS-1:0]   tick_count_o
);

  typedef enum logic [1:0] {
    HALT     = 2'd0,
    RUN      = 2'd1,
    STEP_ACK = 2'd2,
    BURST    = 2'd3
  } state_t;

  state_t                state_q;
  logic                  tick_q;
  logic                  ack_q;
  logic                  done_q;
  logic                  busy_q;
  logic [CNT_BITS-1:0]   count_q;
  logic [DIV_BITS-1:0]   cnt_q;
  logic [BURST_BITS-1:0] rem_q;

  always_ff @(posedge s_clock) begin
    if (reset) begin
      state_q <= HALT;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        HALT: begin
          if (run_i) begin
            state_q <= RUN;
            tick_q  <= 1'b1;
            cnt_q   <= div_i;
            busy_q  <= 1'b1;
            count_q <= count_q + CNT_BITS'(1);
          end else if (burst_start_i) begin
            if (burst_len_i != '0) begin
              state_q <= BURST;
              tick_q  <= 1'b1;
              rem_q   <= burst_len_i - BURST_BITS'(1);
              cnt_q   <= div_i;
              busy_q  <= 1'b1;
              count_q <= count_q + CNT_BITS'(1);
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else if (step_req_i) begin
            state_q <= STEP_ACK;
            tick_q  <= 1'b1;
            busy_q  <= 1'b1;
            count_q <= count_q + CNT_BITS'(1);
          end else begin
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          // Stop is immediate: a low run_i wins even on a tick slot.
          if (!run_i) begin
            state_q <= HALT;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            tick_q  <= 1'b1;
            cnt_q   <= div_i;
            count_q <= count_q + CNT_BITS'(1);
          end else begin
            cnt_q   <= cnt_q - DIV_BITS'(1);
          end
        end
        BURST: begin
          if (cnt_q == '0) begin
            if (rem_q == '0) begin
              state_q <= HALT;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              tick_q  <= 1'b1;
              rem_q   <= rem_q - BURST_BITS'(1);
              cnt_q   <= div_i;
              count_q <= count_q + CNT_BITS'(1);
            end
          end else begin
            cnt_q   <= cnt_q - DIV_BITS'(1);
          end
        end
        STEP_ACK: begin
          // Ack always rises once, even if the request already dropped.
          if (!ack_q) begin
            ack_q   <= 1'b1;
          end else if (!step_req_i) begin
            ack_q   <= 1'b0;
            state_q <= HALT;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= HALT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tick_o       = tick_q;
  assign step_ack_o   = ack_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;
  assign tick_count_o = count_q;

endmodule

// File: doc/tick_sequencer.md
Name: tick_sequencer

Overview:
- Generates the single-cycle `tick_o` enable pulse that drives the `tick` input of the design's register flip-flops. It is the producer side of the register clock-enable/tick interface.
- Operating modes:
  - free-running divided rate;
  - single-step, with a 4-phase request/acknowledge handshake;
  - counted burst.
- Sits beside the core's clock source. One instance fans `tick_o` out to every register bank in the core.

Parameters:
- DIV_BITS, 16, width of the rate divider; ticks are spaced `div_i+1` cycles apart.
- BURST_BITS, 8, width of the burst length.
- CNT_BITS, 16, width of the wrapping issued-tick counter.

Ports:
- `s_clock`, in, 1, block clock; all state updates on its rising edge.
- `reset`, in, 1, synchronous, active-high.
- `run_i`, in, 1, level; free-run request.
- `step_req_i`, in, 1, single-step request (4-phase).
- `step_ack_o`, out, 1, single-step acknowledge.
- `burst_start_i`, in, 1, pulse/level; start a burst from halt.
- `burst_len_i`, in, BURST_BITS, number of ticks in the burst.
- `div_i`, in, DIV_BITS, tick spacing minus one.
- `tick_o`, out, 1, registered one-cycle tick pulse.
- `done_o`, out, 1, one-cycle pulse when a burst completes.
- `busy_o`, out, 1, high when the state is not HALT.
- `tick_count_o`, out, CNT_BITS, total ticks issued; wraps.

Behaviour:
- Reset and clocking:
  - Reset is decided as synchronous, active-high, on clock `s_clock`.
  - Reset state: state=HALT. `tick_o`, `step_ack_o`, `done_o` and `busy_o` are 0; `tick_count_o`, the spacing counter and the remaining-burst count are 0.
  - Reset overrides everything, including mid-burst and mid-handshake. The tick that would otherwise issue on that edge is suppressed.
- Registers and counting:
  - All outputs are registered.
  - `tick_count_o` increments on every edge that sets `tick_o`=1, and wraps from all-ones to 0.
  - The spacing counter `cnt` reloads from `div_i` at each tick. `div_i` is sampled only at reload, so changes take effect after the next tick.
  - `div_i`=0 gives a tick every cycle.
- States: HALT, RUN, STEP_ACK, BURST.
- HALT, entry priority when several requests are present on the same edge: `run_i` > `burst_start_i` > `step_req_i`.
  - `run_i`=1 at edge k: state←RUN, `tick_o`←1, `cnt`←`div_i`.
  - `burst_start_i`=1, `burst_len_i`=N≥1: state←BURST, `tick_o`←1, `rem`←N-1, `cnt`←`div_i`.
  - `burst_start_i`=1, N=0: no tick, `done_o`←1, state stays HALT.
  - `step_req_i`=1: `tick_o`←1, state←STEP_ACK.
  - Otherwise: `tick_o`←0.
- RUN:
  - `run_i`=0 sampled: state←HALT, `tick_o`←0 (stop is immediate; no partial interval completes).
  - Otherwise, if `cnt`==0: `tick_o`←1, `cnt`←`div_i`. Else: `tick_o`←0, `cnt`←`cnt`-1.
  - Ticks land on edges k, k+(D+1), k+2(D+1), …
- BURST:
  - Uses the same spacing rule as RUN. `rem` decrements on each tick after the first.
  - When `cnt`==0 and `rem`==0: `tick_o`←0, `done_o`←1, state←HALT. This is one spacing slot after the last tick.
  - `run_i`, `step_req_i` and `burst_start_i` are ignored until the burst completes.
- STEP_ACK:
  - `tick_o`←0 and `step_ack_o`←1 on the first edge in the state.
  - Remain in STEP_ACK while `step_req_i`=1.
  - When `step_req_i`=0 is sampled: `step_ack_o`←0, state←HALT.
  - A new step is accepted only after the ack has dropped, so exactly one tick is issued per handshake.
- Status outputs:
  - `done_o` is high for exactly one cycle per burst.
  - `busy_o`←(next state != HALT).

Test Plan:
1. Reset held 2 cycles, then released with no requests -> `tick_o`, `busy_o`, `step_ack_o`, `done_o` all 0; `tick_count_o`=0; no ticks for 20 cycles.
2. `div_i`=3, `run_i`=1 for 12 cycles, then 0 -> ticks on cycles 0, 4, 8; no tick after `run_i` is sampled low; `tick_count_o`=3; `busy_o` falls on the same edge.
3. `div_i`=0, `burst_len_i`=5, `burst_start_i` pulse -> 5 consecutive `tick_o` cycles, `done_o` on cycle 5, `tick_count_o`=5. Repeat with `burst_len_i`=0 -> no tick; `done_o` pulses 1 cycle; `busy_o` stays 0.
4. `step_req_i` held high 6 cycles, then low -> exactly 1 tick; `step_ack_o` high from the cycle after the tick until one edge after the request drops; second handshake -> `tick_count_o`=2.
5. `run_i`, `burst_start_i` and `step_req_i` asserted on the same edge from HALT -> RUN selected; no `done_o`, no `step_ack_o`. Mid-burst (`div_i`=2, N=10) assert reset after tick 4 -> `tick_o`=0 on the reset edge, `tick_count_o`=0, state HALT, no `done_o`.
6. `tick_count_o` preloaded near wrap via a 0xFFFE-tick run with `div_i`=0 -> after 3 more ticks `tick_count_o`=1.
